row_pattern_gen: RTL

ROW_PATTERN_GEN -- requirements
Module: row_pattern_gen

---
 rtl/row_pattern_pkg.sv | 29 ++
 rtl/row_pattern_gen_if.sv | 33 +++
 rtl/row_pattern_gen_lfsr10.sv | 30 +++
 rtl/row_pattern_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/row_pattern_pkg.sv
// Shared definitions for row_pattern_gen.
//   state_t      : issue FSM states
//   period()     : issue period in cycles for a difficulty code (9 - d)
//   reload()     : countdown reload value for a difficulty code (period - 2)
//   LFSR_W/TAPS  : pattern LFSR width and feedback taps (x^10 + x^7 + 1)
package row_pattern_pkg;

  localparam int unsigned LFSR_W      = 10;
  localparam int unsigned LFSR_TAP_HI = 10;
  localparam int unsigned LFSR_TAP_LO = 7;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ISSUE
  } state_t;

  function automatic logic [3:0] period(input logic [2:0] d);
    return 4'd9 - {1'b0, d};
  endfunction

  // The countdown spends one edge on load and one on issue, hence the -2.
  function automatic logic [2:0] reload(input logic [2:0] d);
    logic [3:0] p;
    p = period(d) - 4'd2;
    return p[2:0];
  endfunction

endpackage

// File: rtl/row_pattern_gen_if.sv
// Row handshake bundle between the pattern generator and its consumer.
//   row_valid : producer -> consumer, a new row is presented
//   row_ready : consumer -> producer, row accepted this cycle
//   row       : WIDTH cells, gap cells cleared, zero when row_valid is low
//   gap_pos   : lowest gap cell of the current or last row
//   row_count : accepted rows, wrapping 16-bit count
interface row_pattern_gen_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned PW = $clog2(WIDTH);

  logic             row_valid;
  logic             row_ready;
  logic [WIDTH-1:0] row;
  logic [PW-1:0]    gap_pos;
  logic [15:0]      row_count;

  modport master (
    output row_valid,
    output row,
    output gap_pos,
    output row_count,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row,
    input  gap_pos,
    input  row_count,
    output row_ready
  );
endinterface

// File: rtl/row_pattern_gen_lfsr10.sv
// Free-running 10-bit Fibonacci LFSR, x^10 + x^7 + 1, shifting toward MSB.
//   clk     : clock, advances every rising edge
//   reset_n : asynchronous active-low reset, loads seed
//   seed    : reset value (must be nonzero)
//   out     : current LFSR state
module lfsr10
  import row_pattern_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] out
);

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb = r_state[LFSR_TAP_HI-1] ^ r_state[LFSR_TAP_LO-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= seed;
    end else begin
      r_state <= {r_state[LFSR_W-2:0], w_fb};
    end
  end

  assign out = r_state;

endmodule

// File: rtl/row_pattern_gen.sv
// Row pattern generator: issues one row every P(d) = 9 - d enabled cycles.
// Each row has GAP consecutive clear cells starting at gap_pos, all other
// cells set. gap_pos is drawn from an LFSR, optionally limited to move by at
// most MAX_STEP cells from the previous row.
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   enable     : advances the issue countdown
//   difficulty : period select, sampled only at countdown reload
//   bus        : row handshake (row_valid/row_ready/row/gap_pos/row_count)
module row_pattern_gen
  import row_pattern_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter int unsigned     GAP      = 5,
  parameter int unsigned     MAX_STEP = 0,
  parameter logic [9:0]      SEED     = 10'h001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [2:0]         difficulty,
  row_pattern_gen_if.master  bus
);

  localparam int unsigned PW     = $clog2(WIDTH);
  localparam int unsigned NPOS   = WIDTH - GAP + 1;
  localparam int unsigned MAXPOS = WIDTH - GAP;

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_count;
  logic [WIDTH-1:0]  r_row;
  logic [PW-1:0]     r_gap_pos;
  logic              r_have_prev;
  logic [15:0]       r_row_count;

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_row_valid;
  logic              w_load;
  logic              w_dec;
  logic              w_issue;
  logic              w_accept;
  logic [PW-1:0]     w_next_gap;
  logic [WIDTH-1:0]  w_next_row;
  int unsigned       w_pos;
  int unsigned       w_prev;
  int unsigned       w_lo;
  int unsigned       w_hi;

  lfsr10 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (SEED),
    .out     (w_lfsr)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (enable)                    w_next_state = COUNT;
      COUNT:   if (enable && r_count == 3'd0) w_next_state = ISSUE;
      ISSUE:   if (bus.row_ready)             w_next_state = COUNT;
      default:                                w_next_state = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_row_valid = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE:  w_load = enable;
      COUNT: begin
        w_dec   = enable && (r_count != 3'd0);
        w_issue = enable && (r_count == 3'd0);
      end
      ISSUE: begin
        w_row_valid = 1'b1;
        w_accept    = bus.row_ready;
        w_load      = bus.row_ready;
      end
      default: ;
    endcase
  end

  // Candidate gap position, step-limited against the previous row once one exists.
  always_comb begin
    w_prev = 0;
    w_lo   = 0;
    w_hi   = MAXPOS;
    w_pos  = 32'(w_lfsr) % NPOS;
    if (MAX_STEP > 0 && r_have_prev) begin
      w_prev = 32'(r_gap_pos);
      w_lo   = (w_prev > MAX_STEP) ? w_prev - MAX_STEP : 0;
      w_hi   = (w_prev + MAX_STEP < MAXPOS) ? w_prev + MAX_STEP : MAXPOS;
      if (w_pos < w_lo) begin
        w_pos = w_lo;
      end else if (w_pos > w_hi) begin
        w_pos = w_hi;
      end
    end
    w_next_gap = PW'(w_pos);
    w_next_row = '1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i >= w_pos && i < w_pos + GAP) begin
        w_next_row[i] = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_row       <= '0;
      r_gap_pos   <= '0;
      r_have_prev <= 1'b0;
      r_row_count <= '0;
    end else begin
      if (w_load) begin
        r_count <= reload(difficulty);
      end else if (w_dec) begin
        r_count <= r_count - 3'd1;
      end
      if (w_issue) begin
        r_row       <= w_next_row;
        r_gap_pos   <= w_next_gap;
        r_have_prev <= 1'b1;
      end
      if (w_accept) begin
        r_row_count <= r_row_count + 16'd1;
      end
    end
  end

  assign bus.row_valid = w_row_valid;
  assign bus.row       = w_row_valid ? r_row : '0;
  assign bus.gap_pos   = r_gap_pos;
  assign bus.row_count = r_row_count;

endmodule
